// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR pixel prefetch slice: address width, default
// frame geometry, request FSM encoding and the packed pixel-word layout.
package ddr_pkg;

  localparam int unsigned ADDR_W          = 24;
  localparam int unsigned WORD_W          = 32;
  localparam int unsigned PIX_W           = 16;
  localparam int unsigned UCNT_W          = 16;
  localparam int unsigned DEF_LINE_WORDS  = 320;
  localparam int unsigned DEF_FRAME_LINES = 480;
  localparam int unsigned DEF_FIFO_DEPTH  = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } req_state_t;

  // Two 16-bit pixels per DDR word; the low half is displayed first.
  typedef struct packed {
    logic [PIX_W-1:0] hi;
    logic [PIX_W-1:0] lo;
  } pix_word_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous word FIFO between the DDR read side and the pixel consumer.
// Flush has priority over push and pop; pointers wrap modulo DEPTH.
module pixel_fifo
  import ddr_pkg::*;
#(
  parameter  int unsigned DEPTH = DEF_FIFO_DEPTH,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  pix_word_t        wdata,
  input  logic             pop,
  output pix_word_t        rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  pix_word_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_push = push && (count != CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ddr_pixel_prefetch.sv
// Prefetches a frame of 32-bit words from the DDR user port into a small FIFO
// and serves them as 16-bit pixels. Optional macro: UNDERFLOW_COUNT_EN.
module ddr_pixel_prefetch
  import ddr_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 24'h000000,
  parameter int unsigned       LINE_WORDS  = DEF_LINE_WORDS,
  parameter int unsigned       FRAME_LINES = DEF_FRAME_LINES,
  parameter int unsigned       FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frameStart,
  input  logic              pixelReq,
  output logic [PIX_W-1:0]  pixelData,
  output logic              pixelValid,
  output logic              underflow,
  output logic              read,
  output logic [ADDR_W-1:0] readAddress,
  input  logic              readAcknowledge,
  input  logic [WORD_W-1:0] readData
`ifdef UNDERFLOW_COUNT_EN
  ,
  output logic [UCNT_W-1:0] underflowCount
`endif
);

  localparam int unsigned TOTAL_WORDS = LINE_WORDS * FRAME_LINES;
  localparam int unsigned WC_W        = $clog2(TOTAL_WORDS + 1);
  localparam int unsigned CNT_W       = $clog2(FIFO_DEPTH) + 1;

  req_state_t        state;
  req_state_t        state_next;
  logic              read_next;
  logic [ADDR_W-1:0] addr_next;
  logic [WC_W-1:0]   words;
  logic [WC_W-1:0]   words_next;
  logic              frame_active;
  logic              active_next;
  logic              discard;
  logic              discard_next;
  logic              accept;

  logic              half;
  logic              pix_pop;
  pix_word_t         head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;

  // Request FSM: state register and registered DDR-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      read         <= 1'b0;
      readAddress  <= BASE_ADDR;
      words        <= '0;
      frame_active <= 1'b0;
      discard      <= 1'b0;
    end else begin
      state        <= state_next;
      read         <= read_next;
      readAddress  <= addr_next;
      words        <= words_next;
      frame_active <= active_next;
      discard      <= discard_next;
    end
  end

  // Next-state logic. A frameStart during REQ lets the open read finish but
  // marks its data for discard; frameStart in IDLE defers the next request.
  always_comb begin
    state_next   = state;
    discard_next = 1'b0;
    accept       = 1'b0;
    addr_next    = readAddress;
    words_next   = words;
    active_next  = frame_active;

    unique case (state)
      IDLE: begin
        if (frame_active && !frameStart && !readAcknowledge &&
            (words < WC_W'(TOTAL_WORDS)) && (fifo_count < CNT_W'(FIFO_DEPTH)))
          state_next = REQ;
      end
      REQ: begin
        if (readAcknowledge) begin
          state_next = RELEASE;
          accept     = !discard && !frameStart;
        end else begin
          discard_next = discard || frameStart;
        end
      end
      RELEASE: begin
        if (!readAcknowledge) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (frameStart) begin
      addr_next   = BASE_ADDR;
      words_next  = '0;
      active_next = 1'b1;
    end else if (accept) begin
      addr_next   = readAddress + 1'b1;
      words_next  = words + 1'b1;
      active_next = (words_next != WC_W'(TOTAL_WORDS));
    end

    read_next = (state_next == REQ);
  end

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (frameStart),
    .push  (accept),
    .wdata (pix_word_t'(readData)),
    .pop   (pix_pop),
    .rdata (head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  // Pixel side: the head word is released only after its high half is taken.
  assign pix_pop    = pixelReq && !fifo_empty && half && !frameStart;
  assign pixelValid = !fifo_empty;
  assign pixelData  = fifo_empty ? '0 : (half ? head.hi : head.lo);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half      <= 1'b0;
      underflow <= 1'b0;
    end else begin
      underflow <= pixelReq && fifo_empty;
      if (frameStart)                    half <= 1'b0;
      else if (pixelReq && !fifo_empty)  half <= ~half;
    end
  end

`ifdef UNDERFLOW_COUNT_EN
  // Saturating underflow event counter, cleared at every frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      underflowCount <= '0;
    else if (frameStart)
      underflowCount <= '0;
    else if (pixelReq && fifo_empty && (underflowCount != {UCNT_W{1'b1}}))
      underflowCount <= underflowCount + 1'b1;
  end
`endif

endmodule

// File: tb/tb_ddr_pixel_prefetch.sv
// Randomised self-checking bench: a DDR controller model with random ack
// latency feeds two prefetch instances, checked against a pixel queue model.
module tb_ddr_pixel_prefetch;

  localparam logic [23:0] BASE_A = 24'h000000;
  localparam logic [23:0] BASE_B = 24'h000040;

  typedef struct {
    logic [23:0] addr;
    int          t_rise;
    int          t_ack;
    int          t_drop;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fs_a = 1'b0, req_a = 1'b0, fs_b = 1'b0, req_b = 1'b0;
  logic [15:0] pd_a, pd_b;
  logic        pv_a, pv_b, uf_a, uf_b, rd_a, rd_b;
  logic [23:0] ra_a, ra_b;
  logic        ack = 1'b0;
  logic        sel = 1'b0;
  logic        ack_a, ack_b;
  logic [31:0] rdata = 32'h0;
`ifdef UNDERFLOW_COUNT_EN
  logic [15:0] ufc_a, ufc_b;
`endif

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          fs_cyc = 0;
  int          ack_delay = 2;
  int          ack_budget = 0;
  int          read_drops = 0;
  int          exp_ufc = 0;
  bit          push_en = 1'b1;
  logic [31:0] data_q[$];
  logic [15:0] exp_pix[$];
  txn_t        log_q[$];

  assign ack_a = ack & ~sel;
  assign ack_b = ack & sel;

  ddr_pixel_prefetch dut_a (
    .clk(clk), .rst(rst), .frameStart(fs_a), .pixelReq(req_a),
    .pixelData(pd_a), .pixelValid(pv_a), .underflow(uf_a), .read(rd_a),
    .readAddress(ra_a), .readAcknowledge(ack_a), .readData(rdata)
`ifdef UNDERFLOW_COUNT_EN
    , .underflowCount(ufc_a)
`endif
  );

  ddr_pixel_prefetch #(
    .BASE_ADDR(BASE_B), .LINE_WORDS(4), .FRAME_LINES(2), .FIFO_DEPTH(4)
  ) dut_b (
    .clk(clk), .rst(rst), .frameStart(fs_b), .pixelReq(req_b),
    .pixelData(pd_b), .pixelValid(pv_b), .underflow(uf_b), .read(rd_b),
    .readAddress(ra_b), .readAcknowledge(ack_b), .readData(rdata)
`ifdef UNDERFLOW_COUNT_EN
    , .underflowCount(ufc_b)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  function automatic logic cur_read();
    return sel ? rd_b : rd_a;
  endfunction

  function automatic logic [23:0] cur_addr();
    return sel ? ra_b : ra_a;
  endfunction

  // DDR controller model: acks the selected instance after a latency, holds
  // ack until read drops, and records every transaction.
  initial begin : ctrl_model
    txn_t t;
    int   waited;
    int   d;
    logic t_sel;
    forever begin
      @(posedge clk); #1;
      if (!rst && cur_read()) begin
        t_sel    = sel;
        t.addr   = cur_addr();
        t.t_rise = cyc;
        t.t_ack  = -1;
        t.t_drop = -1;
        d = (ack_delay == 0) ? int'($urandom_range(4, 1)) : ack_delay;
        waited = 1;
        while (!rst && sel == t_sel && cur_read() && !(ack_budget > 0 && waited >= d)) begin
          @(posedge clk); #1;
          waited++;
        end
        if (rst || sel != t_sel) continue;
        if (!cur_read()) begin
          read_drops++;
          continue;
        end
        ack = 1'b1;
        rdata = (data_q.size() > 0) ? data_q.pop_front() : $urandom();
        ack_budget--;
        t.t_ack = cyc;
        @(posedge clk); #1;
        if (push_en && !rst) begin
          exp_pix.push_back(rdata[15:0]);
          exp_pix.push_back(rdata[31:16]);
        end
        waited = 0;
        while (!rst && cur_read() && waited < 8) begin
          @(posedge clk); #1;
          waited++;
        end
        if (!cur_read()) t.t_drop = cyc;
        ack = 1'b0;
        log_q.push_back(t);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;
    repeat (3) @(negedge clk);
    exp_pix.delete();
    log_q.delete();
    data_q.delete();
    push_en = 1'b1;
    exp_ufc = 0;
    rst = 1'b0;
  endtask

  task automatic pulse_fs(input logic which_b);
    @(negedge clk);
    if (which_b) fs_b = 1'b1; else fs_a = 1'b1;
    exp_pix.delete();
    log_q.delete();
    exp_ufc = 0;
    @(negedge clk);
    fs_a = 1'b0;
    fs_b = 1'b0;
    fs_cyc = cyc;
  endtask

  task automatic consume_a();
    req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    void'(exp_pix.pop_front());
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (rd_a !== 1'b0 || rd_b !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_read: got a=%b b=%b want 0", rd_a, rd_b);
    end
    vectors++;
    if (ra_a !== BASE_A || ra_b !== BASE_B) begin
      miscompares++;
      $display("FAIL reset_addr: got a=%h b=%h want %h %h", ra_a, ra_b, BASE_A, BASE_B);
    end
    vectors++;
    if (pv_a !== 1'b0 || pd_a !== 16'h0 || uf_a !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_pixel: got valid=%b data=%h uf=%b want 0 0 0", pv_a, pd_a, uf_a);
    end
`ifdef UNDERFLOW_COUNT_EN
    vectors++;
    if (ufc_a !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_ufc: got %0d want 0", ufc_a);
    end
`endif
    rst = 1'b0;
    repeat (20) @(negedge clk);
    vectors++;
    if (log_q.size() != 0 || rd_a !== 1'b0) begin
      miscompares++;
      $display("FAIL no_read_before_frame: got reads=%0d read=%b want 0 0", log_q.size(), rd_a);
    end
  endtask

  task automatic test_first_read();
    ack_delay = 8;
    ack_budget = 100000;
    pulse_fs(1'b0);
    for (int i = 0; i < 200 && log_q.size() < 2; i++) @(negedge clk);
    vectors++;
    if (log_q.size() < 2) begin
      miscompares++;
      $display("FAIL first_read_timeout: got %0d txns want 2", log_q.size());
    end else begin
      vectors++;
      if (log_q[0].addr !== BASE_A || log_q[1].addr !== BASE_A + 24'd1) begin
        miscompares++;
        $display("FAIL first_addr: got %h %h want %h %h", log_q[0].addr, log_q[1].addr,
                 BASE_A, BASE_A + 24'd1);
      end
      vectors++;
      if (log_q[0].t_rise < fs_cyc + 1) begin
        miscompares++;
        $display("FAIL read_after_fs: got rise cycle %0d want >= %0d", log_q[0].t_rise, fs_cyc + 1);
      end
      vectors++;
      if (log_q[0].t_drop != log_q[0].t_ack + 1) begin
        miscompares++;
        $display("FAIL read_release: got drop cycle %0d want %0d", log_q[0].t_drop, log_q[0].t_ack + 1);
      end
      vectors++;
      if (log_q[1].t_rise <= log_q[0].t_drop) begin
        miscompares++;
        $display("FAIL next_read_gap: got rise %0d want > %0d", log_q[1].t_rise, log_q[0].t_drop);
      end
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 800 && log_q.size() < 16; i++) @(negedge clk);
    repeat (30) @(negedge clk);
    vectors++;
    if (log_q.size() != 16 || rd_a !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_stop: got reads=%0d read=%b want 16 0", log_q.size(), rd_a);
    end
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (pv_a !== 1'b1 || pd_a !== exp_pix[0]) begin
        miscompares++;
        $display("FAIL fill_pixel%0d: got valid=%b data=%h want 1 %h", k, pv_a, pd_a, exp_pix[0]);
      end
      consume_a();
    end
    for (int i = 0; i < 60 && log_q.size() < 17; i++) @(negedge clk);
    repeat (30) @(negedge clk);
    vectors++;
    if (log_q.size() != 17) begin
      miscompares++;
      $display("FAIL refill_one: got reads=%0d want 17", log_q.size());
    end else begin
      vectors++;
      if (log_q[16].addr !== BASE_A + 24'd16) begin
        miscompares++;
        $display("FAIL refill_addr: got %h want %h", log_q[16].addr, BASE_A + 24'd16);
      end
    end
  endtask

  task automatic test_split_underflow();
    ack_delay = 2;
    ack_budget = 1;
    data_q.push_back(32'hBEEF_1234);
    pulse_fs(1'b0);
    for (int i = 0; i < 100 && log_q.size() < 1; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    vectors++;
    if (pv_a !== 1'b1 || pd_a !== 16'h1234) begin
      miscompares++;
      $display("FAIL split_low: got valid=%b data=%h want 1 1234", pv_a, pd_a);
    end
    consume_a();
    vectors++;
    if (pv_a !== 1'b1 || pd_a !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL split_high: got valid=%b data=%h want 1 beef", pv_a, pd_a);
    end
    consume_a();
    vectors++;
    if (pv_a !== 1'b0 || pd_a !== 16'h0) begin
      miscompares++;
      $display("FAIL split_empty: got valid=%b data=%h want 0 0", pv_a, pd_a);
    end
    req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    vectors++;
    if (uf_a !== 1'b1 || pd_a !== 16'h0) begin
      miscompares++;
      $display("FAIL underflow_pulse: got uf=%b data=%h want 1 0", uf_a, pd_a);
    end
`ifdef UNDERFLOW_COUNT_EN
    vectors++;
    if (ufc_a !== 16'd1) begin
      miscompares++;
      $display("FAIL underflow_count: got %0d want 1", ufc_a);
    end
`endif
    @(negedge clk);
    vectors++;
    if (uf_a !== 1'b0) begin
      miscompares++;
      $display("FAIL underflow_one_cycle: got uf=%b want 0", uf_a);
    end
  endtask

  task automatic test_fs_in_req();
    // Dut A is parked in REQ at BASE+1 with no acks available.
    push_en = 1'b0;
    pulse_fs(1'b0);
    repeat (5) @(negedge clk);
    vectors++;
    if (rd_a !== 1'b1) begin
      miscompares++;
      $display("FAIL fs_req_hold: got read=%b want 1", rd_a);
    end
    ack_budget = 1;
    for (int i = 0; i < 50 && log_q.size() < 1; i++) @(negedge clk);
    push_en = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (log_q.size() != 1 || log_q[0].addr !== BASE_A + 24'd1 || pv_a !== 1'b0) begin
      miscompares++;
      $display("FAIL fs_req_discard: got txns=%0d valid=%b want 1 0", log_q.size(), pv_a);
    end
    for (int i = 0; i < 20 && rd_a !== 1'b1; i++) @(negedge clk);
    vectors++;
    if (rd_a !== 1'b1 || ra_a !== BASE_A) begin
      miscompares++;
      $display("FAIL fs_req_restart: got read=%b addr=%h want 1 %h", rd_a, ra_a, BASE_A);
    end
    ack_budget = 1;
    for (int i = 0; i < 50 && log_q.size() < 2; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    vectors++;
    if (pv_a !== 1'b1 || exp_pix.size() != 2 || pd_a !== exp_pix[0]) begin
      miscompares++;
      $display("FAIL fs_req_next_word: got valid=%b data=%h want 1 model word", pv_a, pd_a);
    end
  endtask

  task automatic test_random_stream();
    logic exp_valid, exp_uf, prev_req, prev_valid;
    do_reset();
    ack_delay = 0;
    ack_budget = 100000;
    pulse_fs(1'b0);
    exp_uf = 1'b0;
    prev_req = 1'b0;
    prev_valid = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (i > 0) @(negedge clk);
      if (prev_req && prev_valid) void'(exp_pix.pop_front());
      exp_valid = (exp_pix.size() > 0);
      vectors++;
      if (pv_a !== exp_valid || pd_a !== (exp_valid ? exp_pix[0] : 16'h0) || uf_a !== exp_uf) begin
        miscompares++;
        $display("FAIL stream_cycle%0d: got valid=%b data=%h uf=%b want %b %h %b", i, pv_a, pd_a,
                 uf_a, exp_valid, exp_valid ? exp_pix[0] : 16'h0, exp_uf);
      end
      req_a = ($urandom_range(99, 0) < ((i < 400) ? 25 : 85));
      exp_uf = req_a && !exp_valid;
      if (exp_uf && exp_ufc < 65535) exp_ufc++;
      prev_req = req_a;
      prev_valid = exp_valid;
    end
    req_a = 1'b0;
    @(negedge clk);
    foreach (log_q[i]) begin
      vectors++;
      if (log_q[i].addr !== BASE_A + 24'(i) || log_q[i].t_drop != log_q[i].t_ack + 1) begin
        miscompares++;
        $display("FAIL stream_txn%0d: got addr=%h drop=%0d want %h %0d", i, log_q[i].addr,
                 log_q[i].t_drop, BASE_A + 24'(i), log_q[i].t_ack + 1);
      end
    end
    vectors++;
    if (read_drops != 0) begin
      miscompares++;
      $display("FAIL read_dropped: got %0d early drops want 0", read_drops);
    end
`ifdef UNDERFLOW_COUNT_EN
    vectors++;
    if (ufc_a !== 16'(exp_ufc)) begin
      miscompares++;
      $display("FAIL stream_ufc: got %0d want %0d", ufc_a, exp_ufc);
    end
`endif
  endtask

  task automatic test_frame_end();
    do_reset();
    sel = 1'b1;
    ack_delay = 0;
    ack_budget = 100000;
    req_b = 1'b1;
    pulse_fs(1'b1);
    for (int i = 0; i < 400 && log_q.size() < 8; i++) @(negedge clk);
    repeat (40) @(negedge clk);
    vectors++;
    if (log_q.size() != 8 || rd_b !== 1'b0 || pv_b !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_end: got reads=%0d read=%b valid=%b want 8 0 0", log_q.size(), rd_b, pv_b);
    end
    foreach (log_q[i]) begin
      vectors++;
      if (log_q[i].addr !== BASE_B + 24'(i)) begin
        miscompares++;
        $display("FAIL frame_addr%0d: got %h want %h", i, log_q[i].addr, BASE_B + 24'(i));
      end
    end
    pulse_fs(1'b1);
    for (int i = 0; i < 50 && log_q.size() < 1; i++) @(negedge clk);
    vectors++;
    if (log_q.size() < 1) begin
      miscompares++;
      $display("FAIL frame_restart_timeout: got 0 txns want 1");
    end else begin
      vectors++;
      if (log_q[0].addr !== BASE_B || log_q[0].t_rise < fs_cyc + 1) begin
        miscompares++;
        $display("FAIL frame_restart: got addr=%h rise=%0d want %h >=%0d", log_q[0].addr,
                 log_q[0].t_rise, BASE_B, fs_cyc + 1);
      end
    end
    req_b = 1'b0;
    do_reset();
    sel = 1'b0;
  endtask

  initial begin : main
    test_reset();
    test_first_read();
    test_fill();
    test_split_underflow();
    test_fs_in_req();
    test_random_stream();
    test_frame_end();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
